// File: rtl/spi_slave_lite.sv
// spi_slave_lite: oversampling SPI target with a one-entry transmit buffer.
// Define SPI_SLV_REV_EN to add the rev input for LSB-first framing.
module spi_slave_lite #(
   parameter int WLEN        = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            cpol,
   input  logic            cpha,
`ifdef SPI_SLV_REV_EN
   input  logic            rev,
`endif
   input  logic            spi_sck,
   input  logic            spi_mosi,
   input  logic            spi_ssn,
   output logic            spi_miso,
   output logic            spi_misooen,
   input  logic [WLEN-1:0] tx_data,
   input  logic            tx_valid,
   output logic            tx_ready,
   output logic [WLEN-1:0] rx_data,
   output logic            rx_valid,
   output logic            tx_underrun,
   output logic            busy
);
   localparam int CW = $clog2(WLEN);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t r_state;
   logic [SYNC_STAGES-1:0] r_sck_sync, r_mosi_sync, r_ssn_sync;
   logic r_sck_d, r_ssn_d, r_cpol, r_cpha, r_rev;
   logic r_buf_full, r_load_pending, r_rx_valid, r_underrun, r_misooen;
   logic [WLEN-1:0] r_buf, r_tx_shift, r_rx_shift, r_rx_data;
   logic [CW-1:0] r_cnt;
   logic w_sck, w_mosi, w_ssn, w_fall, w_rise, w_lead, w_trail;
   logic w_sample, w_shift, w_load, w_last, w_wr, w_rev_in;
   logic [WLEN-1:0] w_rx_next, w_tx_next, w_tx_load;

`ifdef SPI_SLV_REV_EN
   assign w_rev_in = rev;
`else
   assign w_rev_in = 1'b0;
`endif

   assign w_sck     = r_sck_sync[SYNC_STAGES-1];
   assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
   assign w_ssn     = r_ssn_sync[SYNC_STAGES-1];
   assign w_fall    = r_ssn_d & ~w_ssn;
   assign w_rise    = ~r_ssn_d & w_ssn;
   assign w_lead    = (w_sck ^ r_sck_d) & (w_sck ^ r_cpol);
   assign w_trail   = (w_sck ^ r_sck_d) & ~(w_sck ^ r_cpol);
   assign w_sample  = r_cpha ? w_trail : w_lead;
   assign w_shift   = r_cpha ? w_lead : w_trail;
   assign w_last    = r_cnt == CW'(WLEN - 1);
   assign w_wr      = tx_valid & ~r_buf_full;
   // cpha=0 loads as SSN falls; otherwise a pending load replaces a shift
   assign w_load    = (r_state == IDLE) ? (w_fall & ~r_cpha) : (~w_rise & w_shift & r_load_pending);
   assign w_tx_load = r_buf_full ? r_buf : '0;
   assign w_rx_next = r_rev ? {w_mosi, r_rx_shift[WLEN-1:1]} : {r_rx_shift[WLEN-2:0], w_mosi};
   assign w_tx_next = r_rev ? {1'b0, r_tx_shift[WLEN-1:1]} : {r_tx_shift[WLEN-2:0], 1'b0};

   assign spi_miso    = r_rev ? r_tx_shift[0] : r_tx_shift[WLEN-1];
   assign spi_misooen = r_misooen;
   assign tx_ready    = ~r_buf_full;
   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign tx_underrun = r_underrun;
   assign busy        = r_state == ACTIVE;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state        <= IDLE;
         r_sck_sync     <= '0;
         r_mosi_sync    <= '0;
         r_ssn_sync     <= '0;
         r_sck_d        <= 1'b0;
         r_ssn_d        <= 1'b0;
         r_cpol         <= 1'b0;
         r_cpha         <= 1'b0;
         r_rev          <= 1'b0;
         r_buf_full     <= 1'b0;
         r_buf          <= '0;
         r_load_pending <= 1'b0;
         r_rx_valid     <= 1'b0;
         r_underrun     <= 1'b0;
         r_misooen      <= 1'b1;
         r_tx_shift     <= '0;
         r_rx_shift     <= '0;
         r_rx_data      <= '0;
         r_cnt          <= '0;
      end else begin
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         r_ssn_sync  <= {r_ssn_sync[SYNC_STAGES-2:0], spi_ssn};
         r_sck_d     <= w_sck;
         r_ssn_d     <= w_ssn;
         r_rx_valid  <= 1'b0;
         r_underrun  <= w_load & ~r_buf_full;
         // a write racing an empty-buffer load lands in the buffer, not the shifter
         if (w_wr) begin
            r_buf      <= tx_data;
            r_buf_full <= 1'b1;
         end else if (w_load) r_buf_full <= 1'b0;
         if (r_state == IDLE) begin
            r_cpol         <= cpol;
            r_cpha         <= cpha;
            r_rev          <= w_rev_in;
            r_cnt          <= '0;
            r_load_pending <= 1'b0;
            r_misooen      <= 1'b1;
            if (w_fall) begin
               r_state        <= ACTIVE;
               r_misooen      <= 1'b0;
               r_load_pending <= r_cpha;
               if (!r_cpha) r_tx_shift <= w_tx_load;
            end
         end else if (w_rise) begin
            r_state        <= IDLE;
            r_misooen      <= 1'b1;
            r_cnt          <= '0;
            r_load_pending <= 1'b0;
            r_tx_shift     <= '0;
            r_rx_shift     <= '0;
         end else begin
            if (w_sample) begin
               r_rx_shift <= w_rx_next;
               r_cnt      <= w_last ? '0 : r_cnt + CW'(1);
               if (w_last) begin
                  r_rx_data      <= w_rx_next;
                  r_rx_valid     <= 1'b1;
                  r_load_pending <= 1'b1;
               end
            end
            if (w_shift) begin
               r_tx_shift <= r_load_pending ? w_tx_load : w_tx_next;
               if (r_load_pending) r_load_pending <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_spi_slave_lite.sv
// tb_spi_slave_lite: random SPI frames in all modes checked against a
// word-level model of the transmit buffer, receive words and underruns.
module tb_spi_slave_lite;
   localparam int WLEN  = 8;
   localparam int SS    = 2;
   localparam int HP    = 6;
   localparam int SETUP = 8;

   logic clk = 1'b0, rstn = 1'b0, cpol = 1'b0, cpha = 1'b0;
   logic spi_sck = 1'b0, spi_mosi = 1'b0, spi_ssn = 1'b1, tx_valid = 1'b0;
`ifdef SPI_SLV_REV_EN
   logic rev = 1'b0;
`endif
   logic [WLEN-1:0] tx_data = '0;
   logic spi_miso, spi_misooen, tx_ready, rx_valid, tx_underrun, busy;
   logic [WLEN-1:0] rx_data;

   int n_chk = 0, n_fail = 0, n_ur = 0, ur_exp = 0, nb = 0;
   logic [WLEN-1:0] rx_q[$];
   logic [WLEN-1:0] buf_q[$];
   logic [WLEN-1:0] mw[4];

   always #5 clk = ~clk;

   spi_slave_lite #(.WLEN(WLEN), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rstn(rstn), .cpol(cpol), .cpha(cpha),
`ifdef SPI_SLV_REV_EN
      .rev(rev),
`endif
      .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_ssn(spi_ssn),
      .spi_miso(spi_miso), .spi_misooen(spi_misooen),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
   );

   always @(negedge clk) if (rstn) begin
      if (rx_valid) rx_q.push_back(rx_data);
      if (tx_underrun) n_ur++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_load(output logic [WLEN-1:0] w);
      if (buf_q.size() != 0) w = buf_q.pop_front();
      else begin
         w = '0;
         ur_exp++;
      end
   endtask

   task automatic wr(input logic [WLEN-1:0] v);
      int t = 0;
      while (!tx_ready && t < 40) begin
         tick(1);
         t++;
      end
      check("tx_ready before write", 32'(tx_ready), 1);
      tx_data = v;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      buf_q.push_back(v);
   endtask

   task automatic run_frame(input int nbits, input bit mid, input logic [WLEN-1:0] mid_w, input bit lsb);
      logic [WLEN-1:0] cur, got, seen;
      int nw;
      rx_q.delete();
      n_ur = 0;
      ur_exp = 0;
      cur = '0;
      got = '0;
      seen = '0;
      spi_ssn = 1'b0;
      tick(SETUP);
      check("busy in frame", 32'(busy), 1);
      check("misooen in frame", 32'(spi_misooen), 0);
      for (int b = 0; b < nbits; b++) begin
         int k = b % WLEN;
         int w = b / WLEN;
         int pos = lsb ? k : WLEN - 1 - k;
         if (k == 0) begin
            model_load(cur);
            got = '0;
            seen = '0;
         end
         if (cpha) begin
            spi_sck = ~spi_sck;
            spi_mosi = mw[w][pos];
            tick(HP);
            got[pos] = spi_miso;
            spi_sck = ~spi_sck;
            tick(HP);
         end else begin
            spi_mosi = mw[w][pos];
            tick(HP);
            got[pos] = spi_miso;
            spi_sck = ~spi_sck;
            tick(HP);
            spi_sck = ~spi_sck;
         end
         seen[pos] = 1'b1;
         if (k == WLEN - 1 || b == nbits - 1) check($sformatf("miso word %0d", w), 32'(got), 32'(cur & seen));
         if (mid && b == 2) wr(mid_w);
      end
      if (!cpha && nbits % WLEN == 0) model_load(cur);
      tick(HP);
      spi_ssn = 1'b1;
      tick(SETUP + 4);
      nw = nbits / WLEN;
      check("rx_valid count", rx_q.size(), nw);
      for (int w = 0; w < nw && w < rx_q.size(); w++) check($sformatf("rx_data word %0d", w), 32'(rx_q[w]), 32'(mw[w]));
      check("tx_underrun count", n_ur, ur_exp);
      check("busy idle", 32'(busy), 0);
      check("misooen idle", 32'(spi_misooen), 1);
      check("tx_ready idle", 32'(tx_ready), 32'(buf_q.size() == 0));
   endtask

   task automatic set_mode(input logic [1:0] m);
      {cpol, cpha} = m;
      spi_sck = cpol;
      tick(SETUP);
   endtask

   initial begin
      tick(3);
      check("reset miso", 32'(spi_miso), 0);
      check("reset misooen", 32'(spi_misooen), 1);
      check("reset tx_ready", 32'(tx_ready), 1);
      check("reset rx_data", 32'(rx_data), 0);
      check("reset rx_valid", 32'(rx_valid), 0);
      check("reset tx_underrun", 32'(tx_underrun), 0);
      check("reset busy", 32'(busy), 0);
      rstn = 1'b1;
      tick(SETUP);
      // single-word exchange in every mode
      for (int m = 0; m < 4; m++) begin
         set_mode(2'(m));
         wr(8'hA5);
         mw[0] = 8'h3C;
         run_frame(8, 1'b0, '0, 1'b0);
      end
      // back-to-back words, mode 1 then mode 0
      for (int m = 1; m >= 0; m--) begin
         set_mode(2'(m));
         wr(8'h11);
         mw[0] = 8'hF0;
         mw[1] = 8'h0F;
         run_frame(16, 1'b1, 8'h22, 1'b0);
      end
      // underrun with empty buffer
      set_mode(2'b01);
      mw[0] = 8'h96;
      run_frame(8, 1'b0, '0, 1'b0);
      // abort after 5 bits, then a clean frame
      set_mode(2'b00);
      wr(8'hA5);
      mw[0] = 8'hFF;
      run_frame(5, 1'b0, '0, 1'b0);
      wr(8'h5A);
      mw[0] = 8'h81;
      run_frame(8, 1'b0, '0, 1'b0);
`ifdef SPI_SLV_REV_EN
      rev = 1'b1;
      set_mode(2'b00);
      wr(8'hA5);
      mw[0] = 8'h3C;
      run_frame(8, 1'b0, '0, 1'b1);
      rev = 1'b0;
      tick(SETUP);
`endif
      for (int i = 0; i < 14; i++) begin
         set_mode(2'($urandom_range(0, 3)));
         nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2 * WLEN)) : WLEN * int'($urandom_range(1, 3));
         for (int w = 0; w < 4; w++) mw[w] = WLEN'($urandom);
         if (buf_q.size() == 0 && $urandom_range(0, 3) != 0) wr(WLEN'($urandom));
         run_frame(nb, nb > 3 && $urandom_range(0, 1) == 1, WLEN'($urandom), 1'b0);
      end
      // reset in the middle of a word
      set_mode(2'b00);
      wr(8'hC3);
      spi_ssn = 1'b0;
      tick(SETUP);
      for (int b = 0; b < 3; b++) begin
         spi_mosi = 1'b1;
         tick(HP);
         spi_sck = 1'b1;
         tick(HP);
         spi_sck = 1'b0;
      end
      wr(8'h5A);
      check("busy before reset", 32'(busy), 1);
      #2 rstn = 1'b0;
      #1;
      check("midreset miso", 32'(spi_miso), 0);
      check("midreset misooen", 32'(spi_misooen), 1);
      check("midreset tx_ready", 32'(tx_ready), 1);
      check("midreset rx_data", 32'(rx_data), 0);
      check("midreset rx_valid", 32'(rx_valid), 0);
      check("midreset tx_underrun", 32'(tx_underrun), 0);
      check("midreset busy", 32'(busy), 0);
      buf_q.delete();
      rx_q.delete();
      tick(3);
      rstn = 1'b1;
      for (int b = 0; b < 8; b++) begin
         tick(HP);
         spi_sck = ~spi_sck;
      end
      tick(SETUP);
      check("no resume busy", 32'(busy), 0);
      check("no resume rx", rx_q.size(), 0);
      spi_ssn = 1'b1;
      spi_sck = 1'b0;
      tick(SETUP);
      wr(8'hE7);
      mw[0] = 8'h42;
      run_frame(8, 1'b0, '0, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
